// File: rtl/ram_march_bist.sv
// March C- built-in self-test initiator for a single-port synchronous RAM.
// It walks six march elements over every address and stops at the first
// mismatch, recording the failing address and the data read there.
//
// Handshake with the RAM: a read presents mem_addr with mem_we=0, and the
// data comes back on mem_rdata one clock later. A write presents mem_addr,
// mem_wdata and mem_we=1 in the same cycle. mem_wdata is zero whenever
// mem_we is low.
module ram_march_bist #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] BG = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
  localparam logic [2:0]            LAST_ELEM = 3'd5;

  state_t                  state;
  state_t                  state_next;
  logic [2:0]              elem;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    phase;      // 0 = read cycle, 1 = compare cycle
  logic                    down;
  logic                    addr_last;
  logic                    step_done;
  logic                    mismatch;
  logic                    last_check;
  logic [DATA_WIDTH-1:0]   exp_rd;
  logic [DATA_WIDTH-1:0]   wr_pat;

  // Odd elements read BG and write ~BG; even elements read ~BG and write BG.
  // M0 only writes BG and M5 only reads BG, which fits the same rule.
  assign exp_rd     = elem[0] ? BG : ~BG;
  assign wr_pat     = elem[0] ? ~BG : BG;
  assign down       = (elem == 3'd3) || (elem == 3'd4);
  assign addr_last  = down ? (addr == '0) : (addr == ADDR_MAX);
  assign step_done  = (elem == 3'd0) || phase;
  assign mismatch   = (state == RUN) && (elem != 3'd0) && phase &&
                      (mem_rdata != exp_rd);
  assign last_check = (elem == LAST_ELEM) && phase && addr_last;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (mismatch || last_check) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: RAM port and status strobes
  always_comb begin
    busy      = (state == RUN);
    done      = (state == DONE);
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (state == RUN) begin
      mem_addr = addr;
      mem_we   = (elem == 3'd0) ||
                 (phase && (elem != LAST_ELEM) && !mismatch);
      if (mem_we) mem_wdata = wr_pat;
    end
  end

  // Element / address / phase sequencing; cleared whenever not running
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      elem  <= '0;
      addr  <= '0;
      phase <= 1'b0;
    end else if (state == RUN && state_next == RUN) begin
      if (step_done) begin
        phase <= 1'b0;
        if (addr_last) begin
          elem <= elem + 3'd1;
          // Elements M3 and M4 walk downward from the top address.
          addr <= ((elem == 3'd2) || (elem == 3'd3)) ? ADDR_MAX : '0;
        end else begin
          addr <= down ? addr - 1'b1 : addr + 1'b1;
        end
      end else begin
        phase <= 1'b1;
      end
    end else begin
      elem  <= '0;
      addr  <= '0;
      phase <= 1'b0;
    end
  end

  // Result registers: cleared by an accepted start, set at end of run
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
    end else if (state == IDLE && start) begin
      pass      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
    end else if (state == RUN) begin
      if (mismatch) begin
        pass      <= 1'b0;
        fail_addr <= addr;
        fail_data <= mem_rdata;
      end else if (last_check) begin
        pass <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ram_march_bist.sv
// Directed bench for ram_march_bist: a healthy RAM, two faulty RAMs, start
// re-pulses, an asynchronous mid-run reset, and a second instance with a
// 0x55 background.
module tb_ram_march_bist;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Instance 0 (BG = 0x00)
  logic       start0 = 1'b0;
  logic       busy0, done0, pass0, we0;
  logic [5:0] fa0, addr0;
  logic [7:0] fd0, wdata0, rdata0;

  // Instance 1 (BG = 0x55)
  logic       start1 = 1'b0;
  logic       busy1, done1, pass1, we1;
  logic [5:0] fa1, addr1;
  logic [7:0] fd1, wdata1, rdata1;

  logic [7:0] mem0 [64];
  logic [7:0] mem1 [64];
  int         fault_mode = 0;   // 0 healthy, 1 stuck bit3 @0x15, 2 coupling 0x10->0x20

  int n_cmp = 0;
  int n_bad = 0;

  int busy_cnt0, done_cnt0, wr_cnt0, stray0;
  int busy_cnt1, done_cnt1, wr_cnt1, stray1, badpat1;

  logic       res_pass;
  logic [5:0] res_fa;
  logic [7:0] res_fd;

  ram_march_bist #(.ADDR_WIDTH(6), .DATA_WIDTH(8), .BG(8'h00)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
    .pass(pass0), .fail_addr(fa0), .fail_data(fd0), .mem_addr(addr0),
    .mem_wdata(wdata0), .mem_we(we0), .mem_rdata(rdata0)
  );

  ram_march_bist #(.ADDR_WIDTH(6), .DATA_WIDTH(8), .BG(8'h55)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .pass(pass1), .fail_addr(fa1), .fail_data(fd1), .mem_addr(addr1),
    .mem_wdata(wdata1), .mem_we(we1), .mem_rdata(rdata1)
  );

  // Clock
  always #5 clk = ~clk;

  // RAM 0 with injectable faults
  always @(posedge clk) begin
    if (we0) begin
      if (fault_mode == 1 && addr0 == 6'h15) mem0[addr0] <= wdata0 & 8'hF7;
      else                                   mem0[addr0] <= wdata0;
      if (fault_mode == 2 && addr0 == 6'h10) mem0[6'h20] <= wdata0;
    end
    rdata0 <= mem0[addr0];
  end

  // RAM 1, always healthy
  always @(posedge clk) begin
    if (we1) mem1[addr1] <= wdata1;
    rdata1 <= mem1[addr1];
  end

  // Activity monitors, sampled away from the active edge
  always @(negedge clk) begin
    if (busy0) busy_cnt0++;
    if (done0) done_cnt0++;
    if (we0) wr_cnt0++;
    if (we0 && !busy0) stray0++;
    if (!we0 && wdata0 != 8'h00) stray0++;
    if (busy1) busy_cnt1++;
    if (done1) done_cnt1++;
    if (we1) begin
      wr_cnt1++;
      if (busy_cnt1 <= 64 && wdata1 != 8'h55) badpat1++;
      if (busy_cnt1 > 64 && busy_cnt1 <= 192 && wdata1 != 8'hAA) badpat1++;
    end
    if (!we1 && wdata1 != 8'h00) stray1++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    busy_cnt0 = 0; done_cnt0 = 0; wr_cnt0 = 0; stray0 = 0;
    busy_cnt1 = 0; done_cnt1 = 0; wr_cnt1 = 0; stray1 = 0; badpat1 = 0;
  endtask

  // Start instance 0, optionally re-pulse start at busy cycles 50 and 400,
  // and wait (bounded) for done; results are captured at the done cycle.
  task automatic run0(input bit repulse);
    int k;
    bit seen;
    @(negedge clk);
    clear_counts();
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    k = 1;
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      k++;
      start0 = repulse && (k == 50 || k == 400);
      #1;
      if (done0) begin
        seen = 1'b1;
        break;
      end
    end
    start0 = 1'b0;
    check_eq("done0_timeout", {31'd0, seen}, 32'd1);
    res_pass = pass0;
    res_fa   = fa0;
    res_fd   = fd0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem0[i] = 8'($urandom_range(0, 255));
      mem1[i] = 8'($urandom_range(0, 255));
    end
    clear_counts();

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_busy", {31'd0, busy0}, 32'd0);
    check_eq("rst_done", {31'd0, done0}, 32'd0);
    check_eq("rst_pass", {31'd0, pass0}, 32'd0);
    check_eq("rst_we", {31'd0, we0}, 32'd0);
    check_eq("rst_fail_addr", {26'd0, fa0}, 32'd0);
    check_eq("rst_fail_data", {24'd0, fd0}, 32'd0);
    rst = 1'b0;

    // Healthy RAM
    fault_mode = 0;
    run0(1'b0);
    check_eq("ok_busy_cycles", busy_cnt0, 32'd704);
    check_eq("ok_done_pulses", done_cnt0, 32'd1);
    check_eq("ok_pass", {31'd0, res_pass}, 32'd1);
    check_eq("ok_fail_addr", {26'd0, res_fa}, 32'd0);
    check_eq("ok_fail_data", {24'd0, res_fd}, 32'd0);
    check_eq("ok_writes", wr_cnt0, 32'd320);
    check_eq("ok_stray", stray0, 32'd0);
    check_eq("ok_pass_hold", {31'd0, pass0}, 32'd1);

    // Stuck-at-0 on bit 3 at 0x15: caught in M2
    fault_mode = 1;
    run0(1'b0);
    check_eq("sa_pass", {31'd0, res_pass}, 32'd0);
    check_eq("sa_fail_addr", {26'd0, res_fa}, 32'h15);
    check_eq("sa_fail_data", {24'd0, res_fd}, 32'hF7);
    check_eq("sa_busy_cycles", busy_cnt0, 32'd236);
    check_eq("sa_writes", wr_cnt0, 32'd149);
    check_eq("sa_done_pulses", done_cnt0, 32'd1);
    check_eq("sa_stray", stray0, 32'd0);
    check_eq("sa_fa_hold", {26'd0, fa0}, 32'h15);
    check_eq("sa_fd_hold", {24'd0, fd0}, 32'hF7);

    // Coupling fault: write to 0x10 also lands in 0x20, caught in M1
    fault_mode = 2;
    run0(1'b0);
    check_eq("cf_pass", {31'd0, res_pass}, 32'd0);
    check_eq("cf_fail_addr", {26'd0, res_fa}, 32'h20);
    check_eq("cf_fail_data", {24'd0, res_fd}, 32'hFF);
    check_eq("cf_busy_cycles", busy_cnt0, 32'd130);
    check_eq("cf_writes", wr_cnt0, 32'd96);
    check_eq("cf_stray", stray0, 32'd0);

    // start re-pulsed mid-run is ignored
    fault_mode = 0;
    run0(1'b1);
    check_eq("rp_busy_cycles", busy_cnt0, 32'd704);
    check_eq("rp_done_pulses", done_cnt0, 32'd1);
    check_eq("rp_pass", {31'd0, res_pass}, 32'd1);
    check_eq("rp_writes", wr_cnt0, 32'd320);

    // Asynchronous reset at busy cycle 300 (a write cycle in M2)
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (299) @(negedge clk);
    check_eq("ar_busy_before", {31'd0, busy0}, 32'd1);
    check_eq("ar_we_before", {31'd0, we0}, 32'd1);
    #3 rst = 1'b1;
    #1;
    check_eq("ar_we", {31'd0, we0}, 32'd0);
    check_eq("ar_busy", {31'd0, busy0}, 32'd0);
    check_eq("ar_pass", {31'd0, pass0}, 32'd0);
    check_eq("ar_addr", {26'd0, addr0}, 32'd0);
    #12 rst = 1'b0;
    run0(1'b0);
    check_eq("ar_rerun_busy", busy_cnt0, 32'd704);
    check_eq("ar_rerun_pass", {31'd0, res_pass}, 32'd1);

    // Background 0x55 on instance 1
    @(negedge clk);
    clear_counts();
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    begin
      bit seen1;
      seen1 = 1'b0;
      for (int i = 0; i < 2000; i++) begin
        @(negedge clk);
        #1;
        if (done1) begin
          seen1 = 1'b1;
          break;
        end
      end
      check_eq("bg_done_timeout", {31'd0, seen1}, 32'd1);
    end
    check_eq("bg_pass", {31'd0, pass1}, 32'd1);
    check_eq("bg_busy_cycles", busy_cnt1, 32'd704);
    check_eq("bg_writes", wr_cnt1, 32'd320);
    check_eq("bg_bad_pattern", badpat1, 32'd0);
    check_eq("bg_stray", stray1, 32'd0);
    check_eq("bg_mem00", {24'd0, mem1[0]}, 32'h55);
    check_eq("bg_mem3f", {24'd0, mem1[63]}, 32'h55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
